// File: rtl/uart_arb_pkg.sv
// Shared types and defaults for the packet-level UART transmit arbiter.
package uart_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    WAIT = 2'd2
  } arb_state_e;

  localparam int NUM_REQ_DEF = 3;
  localparam int MAX_LEN_DEF = 16;
  localparam int BYTE_W      = 8;
  localparam int IDX_W       = 3;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set request after the pointer,
// or from index 0 when no packet has been served since reset.
module rr_pick
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  input  logic               ptr_vld,
  output logic [NUM_REQ-1:0] pick,
  output logic [IDX_W-1:0]   idx,
  output logic               found
);

  int start;
  int best;
  int bidx;

  // Smallest rotational distance from the start index wins.
  always_comb begin
    start = ptr_vld ? (int'(ptr) + 1) % NUM_REQ : 0;
    best  = NUM_REQ;
    bidx  = 0;
    pick  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req[i] && (((i + NUM_REQ - start) % NUM_REQ) < best)) begin
        best = (i + NUM_REQ - start) % NUM_REQ;
        bidx = i;
      end
    end
    found = (best < NUM_REQ);
    idx   = IDX_W'(bidx);
    for (int i = 0; i < NUM_REQ; i++) pick[i] = found && (bidx == i);
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among several byte-stream sources; a granted
// source keeps the line until its last byte, a MAX_LEN cutoff, or a dropped req.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int MAX_LEN = MAX_LEN_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [BYTE_W*NUM_REQ-1:0] byte_in,
  input  logic [NUM_REQ-1:0]        last,
  output logic [NUM_REQ-1:0]        byte_ack,
  output logic [NUM_REQ-1:0]        grant,
  output logic                      trmt,
  output logic [BYTE_W-1:0]         tx_data,
  input  logic                      tx_done,
  output logic                      busy,
  output logic                      overrun,
  output logic                      abort
);

  arb_state_e         state, state_n;
  logic [IDX_W-1:0]   owner, owner_n;
  logic [IDX_W-1:0]   ptr, ptr_n;
  logic               ptr_vld, ptr_vld_n;
  logic [7:0]         cnt, cnt_n;
  logic               last_q, last_n;
  logic               first_wait, first_wait_n;
  logic [NUM_REQ-1:0] grant_n, byte_ack_n;
  logic               trmt_n, busy_n, overrun_n, abort_n;
  logic [BYTE_W-1:0]  tx_data_n, own_byte;
  logic               own_req, own_last;
  logic [NUM_REQ-1:0] pick;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_found;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req     (req),
    .ptr     (ptr),
    .ptr_vld (ptr_vld),
    .pick    (pick),
    .idx     (pick_idx),
    .found   (pick_found)
  );

  assign own_req  = |(req & grant);
  assign own_last = |(last & grant);

  always_comb begin
    own_byte = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (grant[i]) own_byte = own_byte | byte_in[BYTE_W*i +: BYTE_W];
  end

  always_comb begin
    state_n      = state;
    owner_n      = owner;
    ptr_n        = ptr;
    ptr_vld_n    = ptr_vld;
    cnt_n        = cnt;
    last_n       = last_q;
    first_wait_n = 1'b0;
    grant_n      = grant;
    busy_n       = busy;
    tx_data_n    = tx_data;
    byte_ack_n   = '0;
    trmt_n       = 1'b0;
    overrun_n    = 1'b0;
    abort_n      = 1'b0;
    case (state)
      IDLE: begin
        if (pick_found) begin
          grant_n = pick;
          owner_n = pick_idx;
          busy_n  = 1'b1;
          cnt_n   = 8'd0;
          state_n = LOAD;
        end
      end
      LOAD: begin
        if (own_req) begin
          tx_data_n    = own_byte;
          trmt_n       = 1'b1;
          byte_ack_n   = grant;
          last_n       = own_last;
          cnt_n        = sat_inc(cnt);
          first_wait_n = 1'b1;
          state_n      = WAIT;
        end else begin
          abort_n   = 1'b1;
          grant_n   = '0;
          busy_n    = 1'b0;
          ptr_n     = owner;
          ptr_vld_n = 1'b1;
          state_n   = IDLE;
        end
      end
      WAIT: begin
        // tx_done is still stale in the first cycle: the UART clears it on the trmt edge.
        if (!first_wait && tx_done) begin
          if (last_q || (cnt == 8'(MAX_LEN))) begin
            overrun_n = !last_q;
            grant_n   = '0;
            busy_n    = 1'b0;
            ptr_n     = owner;
            ptr_vld_n = 1'b1;
            state_n   = IDLE;
          end else begin
            state_n = LOAD;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      owner      <= '0;
      ptr        <= '0;
      ptr_vld    <= 1'b0;
      cnt        <= 8'd0;
      last_q     <= 1'b0;
      first_wait <= 1'b0;
      grant      <= '0;
      byte_ack   <= '0;
      trmt       <= 1'b0;
      tx_data    <= 8'h00;
      busy       <= 1'b0;
      overrun    <= 1'b0;
      abort      <= 1'b0;
    end else begin
      state      <= state_n;
      owner      <= owner_n;
      ptr        <= ptr_n;
      ptr_vld    <= ptr_vld_n;
      cnt        <= cnt_n;
      last_q     <= last_n;
      first_wait <= first_wait_n;
      grant      <= grant_n;
      byte_ack   <= byte_ack_n;
      trmt       <= trmt_n;
      tx_data    <= tx_data_n;
      busy       <= busy_n;
      overrun    <= overrun_n;
      abort      <= abort_n;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench: per-source byte streams and packet-end kinds are predicted
// when stimulus is loaded; a negedge monitor checks every trmt, grant and end pulse.
module tb_uart_tx_arbiter;

  localparam int N    = 3;
  localparam int MAXL = 4;
  localparam logic [1:0] END_LAST = 2'd1;
  localparam logic [1:0] END_OVR  = 2'd2;
  localparam logic [1:0] END_ABT  = 2'd3;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] req;
  logic [8*N-1:0] byte_in;
  logic [N-1:0] last;
  logic [N-1:0] byte_ack;
  logic [N-1:0] grant;
  logic         trmt;
  logic [7:0]   tx_data;
  logic         tx_done;
  logic         busy;
  logic         overrun;
  logic         abort;

  uart_tx_arbiter #(.NUM_REQ(N), .MAX_LEN(MAXL)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .byte_in  (byte_in),
    .last     (last),
    .byte_ack (byte_ack),
    .grant    (grant),
    .trmt     (trmt),
    .tx_data  (tx_data),
    .tx_done  (tx_done),
    .busy     (busy),
    .overrun  (overrun),
    .abort    (abort)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Source stimulus entries (byte, last flag, req-drop marker).
  logic [7:0] sb [4][256];
  bit         sl [4][256];
  bit         sm [4][256];
  logic [7:0] swp [4];
  logic [7:0] srp [4];
  // Expected transmitted bytes and packet-end kinds per source.
  logic [7:0] eb [4][256];
  logic [7:0] ebw [4];
  logic [7:0] ebr [4];
  logic [1:0] ee [4][256];
  logic [7:0] eew [4];
  logic [7:0] eer [4];
  int         gseg [4];

  bit         drv_en, mon_en;
  logic [N-1:0] man_req;
  logic [7:0]   man_byte;
  int         dmin, dmax;
  bit         clr_pend;
  int         ucnt, udly;
  int         m_ptr;
  bit         m_fresh;
  logic [N-1:0] gprev, req_seen;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] oh_idx(input logic [N-1:0] g);
    return g[2] ? 2'd2 : (g[1] ? 2'd1 : 2'd0);
  endfunction

  function automatic logic [N-1:0] rr_ref(input logic [N-1:0] r, input int p, input bit fresh);
    int c;
    for (int k = 0; k < N; k++) begin
      c = fresh ? k : (p + 1 + k) % N;
      if (r[c[1:0]]) return 3'b001 << c;
    end
    return 3'b000;
  endfunction

  function automatic logic [31:0] pack_out();
    return {14'd0, grant, byte_ack, trmt, tx_data, busy, overrun, abort};
  endfunction

  task automatic push_end(input logic [1:0] s, input logic [1:0] kind);
    ee[s][eew[s]] = kind;
    eew[s]++;
  endtask

  task automatic push_byte(input logic [1:0] s, input logic [7:0] b, input bit lst);
    sb[s][swp[s]] = b;
    sl[s][swp[s]] = lst;
    sm[s][swp[s]] = 1'b0;
    swp[s]++;
    eb[s][ebw[s]] = b;
    ebw[s]++;
    gseg[s]++;
    if (lst) begin
      push_end(s, END_LAST);
      gseg[s] = 0;
    end else if (gseg[s] == MAXL) begin
      push_end(s, END_OVR);
      gseg[s] = 0;
    end
  endtask

  task automatic push_drop(input logic [1:0] s);
    sb[s][swp[s]] = 8'h00;
    sl[s][swp[s]] = 1'b0;
    sm[s][swp[s]] = 1'b1;
    swp[s]++;
    if (gseg[s] > 0) begin
      push_end(s, END_ABT);
      gseg[s] = 0;
    end
  endtask

  task automatic add_pkt(input logic [1:0] s, input int len, input bit nolast, input int drop_after);
    for (int j = 0; j < len; j++) begin
      if (drop_after != 0 && j == drop_after) begin
        push_drop(s);
        return;
      end
      push_byte(s, 8'($urandom), !nolast && (j == len - 1));
    end
  endtask

  // A source that runs dry mid-packet drops req, which the arbiter sees as an abort.
  task automatic close_phase();
    for (int k = 0; k < N; k++) begin
      if (gseg[k] > 0) push_end(2'(k), END_ABT);
      gseg[k] = 0;
    end
  endtask

  task automatic open_phase();
    for (int k = 0; k < 4; k++) begin
      swp[k] = 0; srp[k] = 0; ebw[k] = 0; ebr[k] = 0; eew[k] = 0; eer[k] = 0; gseg[k] = 0;
    end
  endtask

  function automatic bit all_empty();
    for (int k = 0; k < N; k++) if (srp[k] != swp[k]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic drain(input int budget);
    bit done;
    done = 1'b0;
    for (int c = 0; c < budget && !done; c++) begin
      @(negedge clk);
      #1;
      done = all_empty() && (grant == 3'b000) && !busy;
    end
    chk("drain_done", {31'd0, done}, 32'd1);
    for (int k = 0; k < N; k++) begin
      chk("bytes_outstanding", ebw[k] - ebr[k], 32'd0);
      chk("ends_outstanding", eew[k] - eer[k], 32'd0);
    end
  endtask

  // Monitor, UART model and source drivers, all at the falling edge.
  initial begin
    logic [1:0] o;
    logic [1:0] kind;
    bit pend;
    forever begin
      @(negedge clk);
      req_seen = req;
      if (mon_en && rst_n) begin
        if (trmt) begin
          chk("uart_idle_at_trmt", {31'd0, tx_done && !clr_pend}, 32'd1);
          chk("grant_onehot_at_trmt", $countones(grant), 32'd1);
          chk("byte_ack_eq_grant", {29'd0, byte_ack}, {29'd0, grant});
          o = oh_idx(grant);
          pend = (ebr[o] != ebw[o]);
          chk("byte_pending", {31'd0, pend}, 32'd1);
          if (pend) begin
            chk("tx_data", {24'd0, tx_data}, {24'd0, eb[o][ebr[o]]});
            ebr[o]++;
          end
        end else if (byte_ack != 3'b000) begin
          chk("ack_without_trmt", {29'd0, byte_ack}, 32'd0);
        end
        if (gprev == 3'b000 && grant != 3'b000) begin
          chk("grant_rr", {29'd0, grant}, {29'd0, rr_ref(req_seen, m_ptr, m_fresh)});
        end else if (gprev != 3'b000 && grant != 3'b000) begin
          chk("grant_stable", {29'd0, grant}, {29'd0, gprev});
        end
        if (gprev != 3'b000 && grant == 3'b000) begin
          o = oh_idx(gprev);
          kind = overrun ? END_OVR : (abort ? END_ABT : END_LAST);
          pend = (eer[o] != eew[o]);
          chk("end_pending", {31'd0, pend}, 32'd1);
          if (pend) begin
            chk("end_kind", {30'd0, kind}, {30'd0, ee[o][eer[o]]});
            eer[o]++;
          end
          chk("end_single_pulse", {31'd0, overrun && abort}, 32'd0);
          m_ptr = int'(o);
          m_fresh = 1'b0;
        end else if (overrun || abort) begin
          chk("stray_end_pulse", {30'd0, overrun, abort}, 32'd0);
        end
        chk("busy_tracks_grant", {31'd0, busy}, {31'd0, grant != 3'b000});
      end
      gprev = grant;

      if (clr_pend) begin
        tx_done = 1'b0;
        ucnt = udly;
        clr_pend = 1'b0;
      end else if (!tx_done && ucnt > 0) begin
        ucnt--;
        if (ucnt == 0) tx_done = 1'b1;
      end
      if (trmt) begin
        clr_pend = 1'b1;
        udly = $urandom_range(dmax, dmin);
      end

      if (drv_en) begin
        for (int k = 0; k < N; k++) begin
          if (byte_ack[k] && srp[k] != swp[k] && !sm[k][srp[k]]) srp[k]++;
          if (srp[k] != swp[k] && sm[k][srp[k]] && !grant[k]) srp[k]++;
          req[k]            = (srp[k] != swp[k]) && !sm[k][srp[k]];
          last[k]           = req[k] && sl[k][srp[k]];
          byte_in[8*k +: 8] = req[k] ? sb[k][srp[k]] : 8'h00;
        end
      end else begin
        req     = man_req;
        last    = 3'b000;
        byte_in = {8'h00, man_byte, man_byte};
      end
    end
  end

  initial begin
    bit seen;
    rst_n = 1'b0; req = '0; byte_in = '0; last = '0; tx_done = 1'b1;
    drv_en = 1'b1; mon_en = 1'b1; man_req = '0; man_byte = 8'h00;
    dmin = 20; dmax = 20; clr_pend = 1'b0; ucnt = 0; udly = 20;
    m_ptr = 0; m_fresh = 1'b1; gprev = '0;
    open_phase();

    // All three sources request from reset, two 2-byte packets each.
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < N; k++) add_pkt(2'(k), 2, 1'b0, 0);
    close_phase();
    repeat (2) @(negedge clk);
    chk("reset_values", pack_out(), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    drain(3000);

    // Source 0 sends AA,55,01,A3; exactly MAX_LEN bytes but ended by last.
    @(posedge clk); #1;
    open_phase();
    push_byte(2'd0, 8'hAA, 1'b0);
    push_byte(2'd0, 8'h55, 1'b0);
    push_byte(2'd0, 8'h01, 1'b0);
    push_byte(2'd0, 8'hA3, 1'b1);
    close_phase();
    drain(3000);

    // Source 2 never flags last (overrun), source 0 waiting behind it.
    @(posedge clk); #1;
    open_phase();
    add_pkt(2'd2, 4, 1'b1, 0);
    add_pkt(2'd0, 2, 1'b0, 0);
    close_phase();
    drain(3000);

    // Source 1 drops req after byte 2 of 5.
    @(posedge clk); #1;
    open_phase();
    add_pkt(2'd1, 5, 1'b0, 2);
    close_phase();
    drain(3000);

    // Randomized traffic with short, varying UART frame times.
    for (int ph = 0; ph < 4; ph++) begin
      @(posedge clk); #1;
      dmin = 2; dmax = 12;
      open_phase();
      for (int p = 0; p < 10; p++) begin
        int len;
        int da;
        bit nl;
        len = $urandom_range(6, 1);
        nl  = ($urandom_range(7, 0) == 0);
        da  = (len > 1 && $urandom_range(7, 0) == 0) ? $urandom_range(len - 1, 1) : 0;
        add_pkt(2'($urandom_range(N - 1, 0)), len, nl, da);
      end
      close_phase();
      drain(6000);
    end

    // Reset while source 1 owns the line and a frame is in flight.
    @(posedge clk); #1;
    dmin = 20; dmax = 20;
    mon_en = 1'b0; drv_en = 1'b0;
    man_req = 3'b010; man_byte = 8'h5A;
    seen = 1'b0;
    for (int c = 0; c < 100 && !seen; c++) begin
      @(negedge clk);
      seen = trmt;
    end
    chk("manual_trmt_seen", {31'd0, seen}, 32'd1);
    repeat (3) @(negedge clk);
    chk("owner_before_reset", {29'd0, grant}, 32'd2);
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("reset_mid_wait", pack_out(), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("grant_after_reset", {29'd0, grant}, 32'd2);
    chk("no_trmt_on_grant", {31'd0, trmt}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
